// File: rtl/mem_responder.sv
// Memory-side responder for the controller strobe port: one read or write per
// mem_clock rising edge, with a ready handshake, low-address write protect and a preload port.
module mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned PROTECT_TOP = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] address,
    input  logic [7:0] to_mem,
    input  logic       mem_write,
    input  logic       mem_clock,
    output logic [7:0] from_mem,
    output logic       ready,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       load_ack,
    output logic       wr_fault
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACCESS  = 2'd2,
        HOLD    = 2'd3
    } state_e;

    function automatic logic [AW-1:0] to_index(input logic [DW-1:0] a);
        return AW'(32'(a) % DEPTH);
    endfunction

    state_e          state_q, state_d;
    logic            strobe_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            we_q, we_d;
    logic            fell_q, fell_d;
    logic [DW-1:0]   from_q, from_d;
    logic            ready_q, ready_d;
    logic            ack_q, ack_d;
    logic            fault_q, fault_d;

    logic [DW-1:0]   mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    logic            strobe_edge_c;
    logic            addr_prot;
    logic [31:0]     protect_top;

    assign protect_top   = PROTECT_TOP;
    assign addr_prot     = 32'(addr_q) < protect_top;
    assign strobe_edge_c = mem_clock & ~strobe_q;

    // Next-state, access and preload decisions
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        fell_d    = fell_q;
        from_d    = from_q;
        ready_d   = 1'b0;
        ack_d     = 1'b0;
        fault_d   = fault_q;
        mem_we    = 1'b0;
        mem_waddr = to_index(load_addr);
        mem_wdata = load_data;

        case (state_q)
            IDLE: begin
                if (strobe_edge_c) begin
                    addr_d  = to_index(address);
                    data_d  = to_mem;
                    we_d    = mem_write;
                    fell_d  = 1'b0;
                    state_d = CAPTURE;
                end else if (load_en) begin
                    mem_we = 1'b1;
                    ack_d  = 1'b1;
                end
            end
            CAPTURE: begin
                if (!mem_clock) fell_d = 1'b1;
                state_d = ACCESS;
                if (we_q && !addr_prot) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q;
                    mem_wdata = data_q;
                    from_d    = data_q;
                end else begin
                    from_d = mem[addr_q];
                    if (we_q) fault_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!mem_clock) fell_d = 1'b1;
                state_d = HOLD;
                ready_d = 1'b1;
            end
            HOLD: begin
                // A fall seen earlier in the access releases HOLD even if the strobe re-rose
                if (!mem_clock || fell_q) begin
                    state_d = IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            strobe_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            fell_q   <= 1'b0;
            from_q   <= '0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= mem_clock;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            fell_q   <= fell_d;
            from_q   <= from_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            fault_q  <= fault_d;
        end
    end

    // Storage survives reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign from_mem = from_q;
    assign ready    = ready_q;
    assign load_ack = ack_q;
    assign wr_fault = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: timeline-based reference model compared every cycle,
// plus directed literal checks and a randomized traffic phase.
module tb_mem_responder;

    localparam int unsigned PT = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] to_mem = '0;
    logic       mem_write = 1'b0;
    logic       mem_clock = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [7:0] from_mem;
    logic       ready;
    logic       load_ack;
    logic       wr_fault;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_responder #(.DEPTH(256), .PROTECT_TOP(PT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .to_mem   (to_mem),
        .mem_write(mem_write),
        .mem_clock(mem_clock),
        .from_mem (from_mem),
        .ready    (ready),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_ack (load_ack),
        .wr_fault (wr_fault)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: an access is a timeline counted in cycles from its strobe edge
    logic [7:0] mem_m [256];
    bit         m_busy = 0, m_prev = 0, m_fell = 0, m_we = 0;
    int         m_age = 0;
    logic [7:0] m_addr = '0, m_data = '0;
    logic [7:0] exp_from = '0;
    bit         exp_ready = 0, exp_ack = 0, exp_fault = 0;

    always @(posedge clock or negedge reset_n) begin : model
        bit edge_s;
        bit was_busy;
        if (!reset_n) begin
            m_busy = 0; m_prev = 0;
            exp_from = '0; exp_ready = 0; exp_ack = 0; exp_fault = 0;
        end else begin
            edge_s   = mem_clock && !m_prev;
            m_prev   = mem_clock;
            was_busy = m_busy;
            exp_ack  = 0;
            if (!was_busy) begin
                if (edge_s) begin
                    m_busy = 1; m_age = 0; m_fell = 0;
                    m_addr = address; m_data = to_mem; m_we = mem_write;
                end else if (load_en) begin
                    mem_m[load_addr] = load_data;
                    exp_ack = 1;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    if (m_we && (int'(m_addr) < int'(PT))) begin
                        exp_from  = mem_m[m_addr];
                        exp_fault = 1;
                    end else if (m_we) begin
                        mem_m[m_addr] = m_data;
                        exp_from = m_data;
                    end else begin
                        exp_from = mem_m[m_addr];
                    end
                end
                if (m_age <= 2) begin
                    if (!mem_clock) m_fell = 1;
                    if (m_age == 2) exp_ready = 1;
                end else if (m_fell || !mem_clock) begin
                    exp_ready = 0;
                    m_busy = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check8("cyc_from_mem", from_mem, exp_from);
        check8("cyc_ready", 8'(ready), 8'(exp_ready));
        check8("cyc_load_ack", 8'(load_ack), 8'(exp_ack));
        check8("cyc_wr_fault", 8'(wr_fault), 8'(exp_fault));
    end

    task automatic do_load(input logic [7:0] a, input logic [7:0] d, output bit got);
        got = 0;
        @(negedge clock);
        load_en = 1'b1; load_addr = a; load_data = d;
        for (int t = 0; t < 64; t++) begin
            @(negedge clock);
            if (load_ack) begin
                got = 1;
                break;
            end
        end
        load_en = 1'b0;
        if (!got) check8("load_ack_timeout", 8'(got), 8'd1);
    endtask

    task automatic do_access(input logic [7:0] a, input logic [7:0] d, input bit we,
                             input int hi, input int gap, output logic [7:0] rd,
                             output bit r1, output bit r2, output bit rl, output bit ra);
        rd = '0; r1 = 0; r2 = 0;
        @(negedge clock);
        address = a; to_mem = d; mem_write = we; mem_clock = 1'b1;
        for (int c = 1; c <= hi; c++) begin
            @(negedge clock);
            if (c == 2) r1 = ready;
            if (c == 3) begin
                r2 = ready;
                rd = from_mem;
            end
        end
        rl = ready;
        mem_clock = 1'b0;
        @(negedge clock);
        ra = ready;
        repeat (gap) @(negedge clock);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] rd;
        logic [7:0] tbl [4];
        bit r1, r2, rl, ra, got, ack_early;
        int acks;
        tbl[0] = 8'hC5; tbl[1] = 8'h41; tbl[2] = 8'hC3; tbl[3] = 8'h4F;

        repeat (3) @(negedge clock);
        check8("reset_from_mem", from_mem, 8'h00);
        check8("reset_ready", 8'(ready), 8'd0);
        check8("reset_load_ack", 8'(load_ack), 8'd0);
        check8("reset_wr_fault", 8'(wr_fault), 8'd0);
        reset_n = 1'b1;

        acks = 0;
        for (int i = 0; i < 4; i++) begin
            do_load(8'(i), tbl[i], got);
            if (got) acks++;
        end
        check8("preload_acks", 8'(acks), 8'd4);
        for (int i = 4; i < 256; i++) do_load(8'(i), 8'(i * 7 + 3), got);

        do_access(8'h02, 8'h00, 1'b0, 3, 1, rd, r1, r2, rl, ra);
        check8("read02_data", rd, 8'hC3);
        check8("read02_ready_n1", 8'(r1), 8'd0);
        check8("read02_ready_n2", 8'(r2), 8'd1);

        do_access(8'h80, 8'hA5, 1'b1, 3, 1, rd, r1, r2, rl, ra);
        check8("write80_from", rd, 8'hA5);
        do_access(8'h80, 8'h00, 1'b0, 3, 1, rd, r1, r2, rl, ra);
        check8("read80_data", rd, 8'hA5);
        check8("write80_fault", 8'(wr_fault), 8'd0);

        do_access(8'h05, 8'hFF, 1'b1, 3, 1, rd, r1, r2, rl, ra);
        check8("prot_write_from", rd, 8'h26);
        check8("prot_write_fault", 8'(wr_fault), 8'd1);
        do_access(8'h05, 8'h00, 1'b0, 3, 1, rd, r1, r2, rl, ra);
        check8("prot_read_back", rd, 8'h26);
        check8("prot_fault_sticky", 8'(wr_fault), 8'd1);

        do_access(8'h03, 8'h00, 1'b0, 10, 1, rd, r1, r2, rl, ra);
        check8("hold_data", rd, 8'h4F);
        check8("hold_ready_before_fall", 8'(rl), 8'd1);
        check8("hold_ready_after_fall", 8'(ra), 8'd0);

        // Strobe edge and preload in the same cycle
        @(negedge clock);
        address = 8'h01; mem_write = 1'b0; mem_clock = 1'b1;
        load_en = 1'b1; load_addr = 8'h40; load_data = 8'h77;
        ack_early = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (load_ack) ack_early = 1;
            if (c == 3) rd = from_mem;
        end
        mem_clock = 1'b0;
        check8("combo_read_data", rd, 8'h41);
        check8("combo_no_early_ack", 8'(ack_early), 8'd0);
        @(negedge clock);
        check8("combo_ack_idle_cycle", 8'(load_ack), 8'd0);
        @(negedge clock);
        check8("combo_ack_after_idle", 8'(load_ack), 8'd1);
        load_en = 1'b0;
        do_access(8'h40, 8'h00, 1'b0, 3, 1, rd, r1, r2, rl, ra);
        check8("combo_load_landed", rd, 8'h77);

        // Reset while in ACCESS
        @(negedge clock);
        address = 8'h90; to_mem = 8'h3C; mem_write = 1'b1; mem_clock = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        mem_clock = 1'b0;
        #1;
        check8("rst_access_from", from_mem, 8'h00);
        check8("rst_access_ready", 8'(ready), 8'd0);
        check8("rst_access_fault", 8'(wr_fault), 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_access(8'h90, 8'h00, 1'b0, 3, 1, rd, r1, r2, rl, ra);
        check8("post_rst_read", rd, 8'h3C);
        check8("post_rst_ready", 8'(r2), 8'd1);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int sel;
            logic [7:0] ra_addr;
            sel = int'($urandom_range(0, 9));
            ra_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            if (sel <= 1) begin
                do_load(ra_addr, 8'($urandom), got);
            end else if (sel == 2) begin
                load_en = 1'b1; load_addr = 8'($urandom); load_data = 8'($urandom);
                do_access(ra_addr, 8'($urandom), 1'($urandom), int'($urandom_range(1, 6)),
                          0, rd, r1, r2, rl, ra);
                got = 0;
                for (int t = 0; t < 64 && !got; t++) begin
                    if (load_ack) got = 1;
                    else @(negedge clock);
                end
                load_en = 1'b0;
                if (!got) check8("rand_combo_ack_timeout", 8'(got), 8'd1);
            end else if (sel == 3) begin
                @(negedge clock);
                address = ra_addr; to_mem = 8'($urandom); mem_write = 1'($urandom);
                mem_clock = 1'b1;
                repeat ($urandom_range(0, 4)) @(negedge clock);
                #2 reset_n = 1'b0;
                mem_clock = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end else begin
                do_access(ra_addr, 8'($urandom), 1'($urandom), int'($urandom_range(1, 12)),
                          int'($urandom_range(0, 3)), rd, r1, r2, rl, ra);
            end
        end

        repeat (6) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
